// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: shift history plus fill count, registered match pulse,
// saturating match counter and a retriggerable LED stretch.
module seq_detect_param #(
    parameter int                 PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1010,
    parameter bit                 OVERLAP  = 1'b1,
    parameter int                 CNT_W    = 8,
    parameter int                 LED_HOLD = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_match,
    output logic [CNT_W-1:0] o_match_count,
    output logic             o_led
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam int LED_W  = $clog2(LED_HOLD + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [LED_W-1:0]  LED_LOAD  = LED_W'(LED_HOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Only PAT_LEN-1 past bits are kept; the incoming bit completes the window.
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LED_W-1:0]   led_q, led_d;

    logic [PAT_LEN-1:0] window;
    logic [FILL_W-1:0]  fill_inc;
    logic               hit;

    always_comb begin
        window   = {hist_q, i_bit};
        fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        hit      = i_valid && (fill_inc == FILL_FULL) && (window == PATTERN);

        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        led_d   = (led_q != '0) ? led_q - LED_W'(1) : led_q;

        // Clear wins over a bit that would complete a match at the same edge.
        if (i_clear) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            led_d  = '0;
        end else begin
            if (i_valid) begin
                hist_d = window[PAT_LEN-2:0];
                fill_d = fill_inc;
            end
            if (hit) begin
                match_d = 1'b1;
                led_d   = LED_LOAD;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!OVERLAP) begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            led_q   <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    assign o_match       = match_q;
    assign o_match_count = cnt_q;
    assign o_led         = (led_q != '0);

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (overlap, non-overlap, 2-bit counter) share the
// same stimulus and are checked against directed expectations and a stream-based model.
module tb_seq_detect_param;

    localparam int PAT_LEN  = 4;
    localparam int LED_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic bitv = 1'b0;
    logic clear = 1'b0;

    logic       m0, m1, m2, l0, l1, l2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    logic       act_match [3];
    logic [7:0] act_cnt   [3];
    logic       act_led   [3];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: every consumed bit since time zero, plus the index where each
    // instance's fresh history begins.
    bit   stream[$];
    int   start     [3];
    bit   exp_match [3];
    int   exp_cnt   [3];
    int   exp_led   [3];
    int   cnt_max   [3] = '{255, 255, 3};
    bit   ovl       [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] pat = 4'b1010;

    always #5 clk = ~clk;

    seq_detect_param dut_ovl (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_bit(bitv), .i_clear(clear),
        .o_match(m0), .o_match_count(c0), .o_led(l0)
    );

    seq_detect_param #(.OVERLAP(1'b0)) dut_novl (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_bit(bitv), .i_clear(clear),
        .o_match(m1), .o_match_count(c1), .o_led(l1)
    );

    seq_detect_param #(.CNT_W(2)) dut_sat (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_bit(bitv), .i_clear(clear),
        .o_match(m2), .o_match_count(c2), .o_led(l2)
    );

    assign act_match[0] = m0;
    assign act_match[1] = m1;
    assign act_match[2] = m2;
    assign act_cnt[0]   = c0;
    assign act_cnt[1]   = c1;
    assign act_cnt[2]   = {6'b0, c2};
    assign act_led[0]   = l0;
    assign act_led[1]   = l1;
    assign act_led[2]   = l2;

    function automatic void model_reset();
        for (int m = 0; m < 3; m++) begin
            start[m]     = stream.size();
            exp_match[m] = 1'b0;
            exp_cnt[m]   = 0;
            exp_led[m]   = 0;
        end
    endfunction

    function automatic void model_edge(bit v, bit b, bit c);
        int n;
        bit hit;
        if (v && !c) stream.push_back(b);
        n = stream.size();
        for (int m = 0; m < 3; m++) begin
            exp_match[m] = 1'b0;
            if (c) begin
                start[m]   = n;
                exp_cnt[m] = 0;
                exp_led[m] = 0;
            end else begin
                if (exp_led[m] > 0) exp_led[m]--;
                hit = 1'b0;
                if (v && (n - start[m] >= PAT_LEN)) begin
                    hit = 1'b1;
                    for (int i = 0; i < PAT_LEN; i++)
                        if (stream[n-PAT_LEN+i] != pat[PAT_LEN-1-i]) hit = 1'b0;
                end
                if (hit) begin
                    exp_match[m] = 1'b1;
                    if (exp_cnt[m] < cnt_max[m]) exp_cnt[m]++;
                    exp_led[m] = LED_HOLD;
                    if (!ovl[m]) start[m] = n;
                end
            end
        end
    endfunction

    // Drive one edge's inputs, let the edge happen, advance the model, settle 1 time unit.
    task automatic tick(input bit v, input bit b, input bit c);
        valid = v;
        bitv  = b;
        clear = c;
        @(posedge clk);
        model_edge(v, b, c);
        #1;
        valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int m = 0; m < 3; m++) begin
            n_cmp += 3;
            if (act_match[m] !== 1'b0) begin
                n_err++; $display("FAIL reset_match[%0d]: got %b want 0", m, act_match[m]);
            end
            if (act_cnt[m] !== 8'd0) begin
                n_err++; $display("FAIL reset_count[%0d]: got %0d want 0", m, act_cnt[m]);
            end
            if (act_led[m] !== 1'b0) begin
                n_err++; $display("FAIL reset_led[%0d]: got %b want 0", m, act_led[m]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_overlap();
        bit bits [6] = '{1, 0, 1, 0, 1, 0};
        bit em   [6] = '{0, 0, 0, 1, 0, 1};
        int ec   [6] = '{0, 0, 0, 1, 1, 2};
        bit el   [6] = '{0, 0, 0, 1, 1, 1};
        bit el_idle [4] = '{1, 1, 1, 0};
        tick(0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            tick(1, bits[i], 0);
            n_cmp += 3;
            if (m0 !== em[i]) begin
                n_err++; $display("FAIL overlap_match bit%0d: got %b want %b", i + 1, m0, em[i]);
            end
            if (c0 !== 8'(ec[i])) begin
                n_err++; $display("FAIL overlap_count bit%0d: got %0d want %0d", i + 1, c0, ec[i]);
            end
            if (l0 !== el[i]) begin
                n_err++; $display("FAIL overlap_led bit%0d: got %b want %b", i + 1, l0, el[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0);
            n_cmp += 2;
            if (l0 !== el_idle[i]) begin
                n_err++; $display("FAIL overlap_led_idle%0d: got %b want %b", i, l0, el_idle[i]);
            end
            if (m0 !== 1'b0) begin
                n_err++; $display("FAIL overlap_idle_match%0d: got %b want 0", i, m0);
            end
        end
    endtask

    task automatic test_nonoverlap();
        bit bits [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        bit em   [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int ec   [8] = '{0, 0, 0, 1, 1, 1, 1, 2};
        tick(0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            tick(1, bits[i], 0);
            n_cmp += 2;
            if (m1 !== em[i]) begin
                n_err++; $display("FAIL novl_match bit%0d: got %b want %b", i + 1, m1, em[i]);
            end
            if (c1 !== 8'(ec[i])) begin
                n_err++; $display("FAIL novl_count bit%0d: got %0d want %0d", i + 1, c1, ec[i]);
            end
        end
    endtask

    task automatic test_valid_gaps();
        bit vs [7] = '{1, 0, 1, 0, 1, 0, 1};
        bit bs [7] = '{1, 1, 0, 0, 1, 1, 0};
        bit em [7] = '{0, 0, 0, 0, 0, 0, 1};
        tick(0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            tick(vs[i], bs[i], 0);
            n_cmp++;
            if (m0 !== em[i]) begin
                n_err++; $display("FAIL gaps_match step%0d: got %b want %b", i, m0, em[i]);
            end
        end
        tick(0, 0, 0);
        n_cmp += 2;
        if (m0 !== 1'b0) begin
            n_err++; $display("FAIL gaps_pulse_width: got %b want 0", m0);
        end
        if (c0 !== 8'd1) begin
            n_err++; $display("FAIL gaps_count: got %0d want 1", c0);
        end
    endtask

    task automatic test_saturation();
        bit bits [6] = '{1, 0, 1, 0, 0, 0};
        int want;
        tick(0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            want = (k + 1 < 3) ? k + 1 : 3;
            for (int i = 0; i < 6; i++) begin
                tick(1, bits[i], 0);
                if (i == 3) begin
                    n_cmp += 2;
                    if (m2 !== 1'b1) begin
                        n_err++; $display("FAIL sat_pulse match%0d: got %b want 1", k + 1, m2);
                    end
                    if (c2 !== 2'(want)) begin
                        n_err++; $display("FAIL sat_count match%0d: got %0d want %0d", k + 1, c2, want);
                    end
                end else if (i == 4) begin
                    n_cmp++;
                    if (m2 !== 1'b0) begin
                        n_err++; $display("FAIL sat_pulse_end match%0d: got %b want 0", k + 1, m2);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit pre  [7] = '{1, 0, 1, 0, 1, 0, 1};
        bit post [4] = '{1, 0, 1, 0};
        bit em   [4] = '{0, 0, 0, 1};
        tick(0, 0, 1);
        for (int i = 0; i < 7; i++) tick(1, pre[i], 0);
        n_cmp++;
        if (c0 !== 8'd2) begin
            n_err++; $display("FAIL arst_pre_count: got %0d want 2", c0);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp += 3;
        if (m0 !== 1'b0) begin
            n_err++; $display("FAIL arst_match: got %b want 0", m0);
        end
        if (c0 !== 8'd0) begin
            n_err++; $display("FAIL arst_count: got %0d want 0", c0);
        end
        if (l0 !== 1'b0) begin
            n_err++; $display("FAIL arst_led: got %b want 0", l0);
        end
        #1;
        rst = 1'b0;
        tick(1, 0, 0);
        n_cmp++;
        if (m0 !== 1'b0) begin
            n_err++; $display("FAIL arst_stale_prefix: got %b want 0", m0);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1, post[i], 0);
            n_cmp++;
            if (m0 !== em[i]) begin
                n_err++; $display("FAIL arst_rematch bit%0d: got %b want %b", i + 1, m0, em[i]);
            end
        end
        n_cmp++;
        if (c0 !== 8'd1) begin
            n_err++; $display("FAIL arst_post_count: got %0d want 1", c0);
        end
    endtask

    task automatic test_clear_collision();
        bit pre [7] = '{1, 0, 1, 0, 1, 0, 1};
        tick(0, 0, 1);
        for (int i = 0; i < 7; i++) tick(1, pre[i], 0);
        tick(1, 0, 1);
        n_cmp += 3;
        if (m0 !== 1'b0) begin
            n_err++; $display("FAIL clr_match: got %b want 0", m0);
        end
        if (c0 !== 8'd0) begin
            n_err++; $display("FAIL clr_count: got %0d want 0", c0);
        end
        if (l0 !== 1'b0) begin
            n_err++; $display("FAIL clr_led: got %b want 0", l0);
        end
        tick(1, 1, 0);
        tick(1, 0, 0);
        n_cmp += 2;
        if (m0 !== 1'b0) begin
            n_err++; $display("FAIL clr_history_match: got %b want 0", m0);
        end
        if (c0 !== 8'd0) begin
            n_err++; $display("FAIL clr_history_count: got %0d want 0", c0);
        end
    endtask

    task automatic test_random();
        bit v, b, c;
        tick(0, 0, 1);
        for (int cyc = 0; cyc < 800; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            b = $urandom_range(0, 1);
            c = ($urandom_range(0, 79) == 0);
            tick(v, b, c);
            for (int m = 0; m < 3; m++) begin
                n_cmp += 3;
                if (act_match[m] !== exp_match[m]) begin
                    n_err++; $display("FAIL rand_match[%0d] cyc%0d: got %b want %b", m, cyc, act_match[m], exp_match[m]);
                end
                if (act_cnt[m] !== 8'(exp_cnt[m])) begin
                    n_err++; $display("FAIL rand_count[%0d] cyc%0d: got %0d want %0d", m, cyc, act_cnt[m], exp_cnt[m]);
                end
                if (act_led[m] !== (exp_led[m] != 0)) begin
                    n_err++; $display("FAIL rand_led[%0d] cyc%0d: got %b want %b", m, cyc, act_led[m], exp_led[m] != 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_valid_gaps();
        test_saturation();
        test_async_reset();
        test_clear_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
